// File: rtl/ranger_pkg.sv
// Shared constants for the ultrasonic ranger: FSM encodings,
// 50 MHz timing defaults and the result width.
package ranger_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_TRIG    = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_MEASURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_HOLDOFF = 3'd5;

    localparam int TRIG_CYCLES_DEF      = 500;
    localparam int CYCLES_PER_CM_DEF    = 2900;
    localparam int MAX_CM_DEF           = 400;
    localparam int ECHO_WAIT_CYCLES_DEF = 1_500_000;
    localparam int PERIOD_CYCLES_DEF    = 3_000_000;

    localparam int DIST_W = 32;

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// Distance result stream from the ranger to the car counter.
interface ultrasonic_ranger_if;
    import ranger_pkg::*;

    logic [DIST_W-1:0] distance;
    logic              distance_ready;
    logic              timeout;

    modport master (
        output distance,
        output distance_ready,
        output timeout
    );

    modport slave (
        input distance,
        input distance_ready,
        input timeout
    );

endinterface

// File: rtl/ultrasonic_ranger_sync_edge.sv
// Two-flop synchronizer plus previous-value flop for an async GPIO
// input; reports the synchronized level and single-cycle edges.
module sync_edge (
    input  logic clk,
    input  logic reset_l,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign sync_o = s2_q;
    assign rise_o = s2_q & ~prev_q;
    assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo width timing and
// prescaled conversion to centimetres with missing/stuck echo timeout.
module ultrasonic_ranger
    import ranger_pkg::*;
#(
    parameter int TRIG_CYCLES      = TRIG_CYCLES_DEF,
    parameter int CYCLES_PER_CM    = CYCLES_PER_CM_DEF,
    parameter int MAX_CM           = MAX_CM_DEF,
    parameter int ECHO_WAIT_CYCLES = ECHO_WAIT_CYCLES_DEF,
    parameter int PERIOD_CYCLES    = PERIOD_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_l,
    input  logic enable,
    input  logic echo,
    output logic trigger,
    output logic busy,
    ultrasonic_ranger_if.master res
);

    localparam int TW  = $clog2(TRIG_CYCLES + 1);
    localparam int WW  = $clog2(ECHO_WAIT_CYCLES + 1);
    localparam int PRW = $clog2(CYCLES_PER_CM + 1);
    localparam int CW  = $clog2(MAX_CM + 1);
    localparam int PW  = $clog2(PERIOD_CYCLES + 1);

    localparam logic [TW-1:0]     TRIG_LAST = TW'(TRIG_CYCLES - 1);
    localparam logic [WW-1:0]     WAIT_LAST = WW'(ECHO_WAIT_CYCLES - 1);
    localparam logic [PRW-1:0]    PRE_LAST  = PRW'(CYCLES_PER_CM - 1);
    localparam logic [CW-1:0]     CM_LAST   = CW'(MAX_CM - 1);
    localparam logic [PW-1:0]     PER_LAST  = PW'(PERIOD_CYCLES - 1);
    localparam logic [DIST_W-1:0] DIST_MAX  = DIST_W'(MAX_CM);

    logic [2:0]        state_q, state_d;
    logic [TW-1:0]     trig_q, trig_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [PRW-1:0]    pre_q, pre_d;
    logic [CW-1:0]     cm_q, cm_d;
    logic [PW-1:0]     per_q, per_d;
    logic [DIST_W-1:0] dist_q, dist_d;
    logic              rdy_q, rdy_d;
    logic              to_q, to_d;

    logic unused_echo_lvl;
    logic echo_rise;
    logic echo_fall;
    logic wrap;
    logic done_go;
    logic done_to;

    sync_edge u_sync (
        .clk     (clk),
        .reset_l (reset_l),
        .d_i     (echo),
        .sync_o  (unused_echo_lvl),
        .rise_o  (echo_rise),
        .fall_o  (echo_fall)
    );

    assign wrap = (pre_q == PRE_LAST);

    always_comb begin
        state_d = state_q;
        trig_d  = trig_q;
        wait_d  = wait_q;
        pre_d   = pre_q;
        cm_d    = cm_q;
        done_go = 1'b0;
        done_to = 1'b0;
        // Trigger-to-trigger spacing counter saturates, never wraps
        per_d   = (per_q >= PER_LAST) ? per_q : per_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_TRIG;
                    trig_d  = '0;
                    per_d   = '0;
                end
            end
            ST_TRIG: begin
                if (trig_q == TRIG_LAST) begin
                    state_d = ST_WAIT;
                    wait_d  = '0;
                end else begin
                    trig_d = trig_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (echo_rise) begin
                    state_d = ST_MEASURE;
                    pre_d   = '0;
                    cm_d    = '0;
                end else if (wait_q == WAIT_LAST) begin
                    done_go = 1'b1;
                    done_to = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_MEASURE: begin
                // The fall cycle itself is counted as an echo-high cycle
                if (wrap) begin
                    pre_d = '0;
                    cm_d  = cm_q + 1'b1;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
                if (echo_fall) begin
                    done_go = 1'b1;
                end else if (wrap && cm_q == CM_LAST) begin
                    done_go = 1'b1;
                    done_to = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (per_q >= PER_LAST) begin
                    if (enable) begin
                        state_d = ST_TRIG;
                        trig_d  = '0;
                        per_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (done_go) begin
            state_d = ST_DONE;
        end

        rdy_d  = done_go;
        to_d   = done_go & done_to;
        dist_d = dist_q;
        if (done_go) begin
            dist_d = done_to ? DIST_MAX : DIST_W'(cm_d);
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= ST_IDLE;
            trig_q  <= '0;
            wait_q  <= '0;
            pre_q   <= '0;
            cm_q    <= '0;
            per_q   <= '0;
            dist_q  <= '0;
            rdy_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            trig_q  <= trig_d;
            wait_q  <= wait_d;
            pre_q   <= pre_d;
            cm_q    <= cm_d;
            per_q   <= per_d;
            dist_q  <= dist_d;
            rdy_q   <= rdy_d;
            to_q    <= to_d;
        end
    end

    assign trigger            = (state_q == ST_TRIG);
    assign busy               = (state_q != ST_IDLE);
    assign res.distance       = dist_q;
    assign res.distance_ready = rdy_q;
    assign res.timeout        = to_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with shortened sim timing.
module tb_ultrasonic_ranger;

    localparam int TRIG  = 5;
    localparam int CPC   = 10;
    localparam int MAXCM = 20;
    localparam int EWAIT = 50;
    localparam int PER   = 300;

    logic clk     = 1'b0;
    logic reset_l = 1'b0;
    logic enable  = 1'b0;
    logic echo    = 1'b0;
    logic trigger;
    logic busy;

    ultrasonic_ranger_if res_if ();

    ultrasonic_ranger #(
        .TRIG_CYCLES      (TRIG),
        .CYCLES_PER_CM    (CPC),
        .MAX_CM           (MAXCM),
        .ECHO_WAIT_CYCLES (EWAIT),
        .PERIOD_CYCLES    (PER)
    ) dut (
        .clk     (clk),
        .reset_l (reset_l),
        .enable  (enable),
        .echo    (echo),
        .trigger (trigger),
        .busy    (busy),
        .res     (res_if.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rdy_seen = 0;
    always @(negedge clk) if (res_if.distance_ready) rdy_seen++;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_trig(input string tag, output int t);
        int k;
        k = 0;
        @(negedge clk);
        while (!trigger && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_trig_seen"}, 32'(trigger), 1);
        t = cyc;
    endtask

    // n>0: echo pulse of n cycles; n==0: leave echo; n<0: raise and hold
    task automatic run_meas(input string tag, input int n,
                            input int exp_d, input int exp_to,
                            input bit drop, output int t_trig,
                            output int t_fall, output int t_rdy);
        int w;
        int k;
        wait_trig(tag, t_trig);
        w = 0;
        while (trigger && w < 100) begin
            w++;
            @(negedge clk);
        end
        chk({tag, "_trig_width"}, w, TRIG);
        t_fall = cyc;
        if (n != 0) begin
            echo = 1'b0;
            repeat (3) @(negedge clk);
            echo = 1'b1;
        end
        if (n > 0) begin
            for (int i = 0; i < n; i++) begin
                if (drop && i == n / 2) enable = 1'b0;
                @(negedge clk);
            end
            echo = 1'b0;
        end
        k = 0;
        while (!res_if.distance_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_ready"}, 32'(res_if.distance_ready), 1);
        t_rdy = cyc;
        chk({tag, "_distance"}, res_if.distance, exp_d);
        chk({tag, "_timeout"}, 32'(res_if.timeout), exp_to);
    endtask

    int t0, t1, tf, tr, r0, hits;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_trigger", 32'(trigger), 0);
        chk("rst_distance", res_if.distance, 0);
        chk("rst_ready", 32'(res_if.distance_ready), 0);
        chk("rst_timeout", 32'(res_if.timeout), 0);
        chk("rst_busy", 32'(busy), 0);

        reset_l = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        run_meas("nom", 125, 12, 0, 1'b0, t0, tf, tr);
        @(negedge clk);
        chk("nom_ready_1cyc", 32'(res_if.distance_ready), 0);

        run_meas("noecho", 0, MAXCM, 1, 1'b0, t1, tf, tr);
        chk("nom_period", t1 - t0, PER);
        chk("noecho_latency", tr - tf, EWAIT);

        run_meas("stuck", -1, MAXCM, 1, 1'b0, t0, tf, tr);
        run_meas("ignore", 0, MAXCM, 1, 1'b0, t0, tf, tr);
        chk("ignore_latency", tr - tf, EWAIT);

        run_meas("b9", 9, 0, 0, 1'b0, t0, tf, tr);
        run_meas("b10", 10, 1, 0, 1'b0, t0, tf, tr);
        run_meas("b199", 199, 19, 0, 1'b0, t0, tf, tr);
        run_meas("b200", 200, 20, 0, 1'b0, t0, tf, tr);

        run_meas("drop", 50, 5, 0, 1'b1, t0, tf, tr);
        hits = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (trigger) hits++;
        end
        chk("drop_no_trigger", hits, 0);
        chk("drop_idle_busy", 32'(busy), 0);

        enable = 1'b1;
        wait_trig("rst_mid", t0);
        repeat (10) @(negedge clk);
        echo = 1'b1;
        repeat (25) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        r0 = rdy_seen;
        #2 reset_l = 1'b0;
        #1;
        chk("async_trigger", 32'(trigger), 0);
        chk("async_distance", res_if.distance, 0);
        chk("async_ready", 32'(res_if.distance_ready), 0);
        chk("async_busy", 32'(busy), 0);
        echo = 1'b0;
        repeat (3) @(negedge clk);
        reset_l = 1'b1;
        chk("rst_no_ready", rdy_seen, r0);

        run_meas("restart", 30, 3, 0, 1'b0, t0, tf, tr);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ultrasonic_ranger.md
Name: ultrasonic_ranger

Overview:
Drives an HC-SR04-style ultrasonic sensor and produces the distance and distance_ready stream consumed by the car counter. Repeatedly issues a trigger pulse and times the echo pulse width. Converts the width to centimetres using a prescaler, so no divider is needed, and handles missing or stuck echoes with a timeout. Sits between the GPIO pins and the car counter.

Parameters:
TRIG_CYCLES, 500, trigger high time in clk cycles (10 us at 50 MHz).
CYCLES_PER_CM, 2900, echo-high clk cycles per 1 cm (58 us at 50 MHz).
MAX_CM, 400, maximum reportable distance; reaching it means timeout.
ECHO_WAIT_CYCLES, 1_500_000, max cycles from trigger fall to echo rise (30 ms).
PERIOD_CYCLES, 3_000_000, minimum trigger-to-trigger spacing (60 ms).

Ports:
clk  in  1  system clock
reset_l  in  1  asynchronous, active-low reset
enable  in  1  level; measurements run while high
echo  in  1  raw sensor echo pin, asynchronous to clk
trigger  out  1  sensor trigger pin
distance  out  32  last measured distance in cm, zero-extended
distance_ready  out  1  one-cycle pulse; new distance valid
timeout  out  1  one-cycle pulse coincident with distance_ready when the measurement timed out
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: trigger=0, distance=0, distance_ready=0, timeout=0, busy=0, state=IDLE, all counters 0. Reset is legal mid-measurement; it aborts immediately with no ready pulse.
- echo passes through a 2-FF synchronizer, then a previous-value FF. Rise = sync&~prev; fall = ~sync&prev. Only edges are used, never raw level.
- IDLE: on enable=1, go to TRIG and clear period_cnt.
- TRIG: trigger=1 for exactly TRIG_CYCLES cycles, then trigger=0 and go to WAIT_ECHO.
- WAIT_ECHO:
  - On a rise event, clear the prescaler and cm count, then go to MEASURE.
  - If ECHO_WAIT_CYCLES elapse with no rise, go to DONE with the timeout flag set.
  - An echo already high on entry is ignored until it falls and rises again.
- MEASURE:
  - Prescaler counts 0..CYCLES_PER_CM-1. On wrap, cm count increments.
  - On a fall event, latch cm count and go to DONE.
  - If cm count reaches MAX_CM before a fall, go to DONE with the timeout flag set (stuck echo).
  - A fall and a saturation in the same cycle count as a fall (valid).
- DONE, one cycle:
  - Valid result: distance <= cm count.
  - Timeout: distance <= MAX_CM.
  - distance_ready=1 this cycle; timeout=1 on the timeout path only.
  - Then go to HOLDOFF.
- HOLDOFF: wait until period_cnt >= PERIOD_CYCLES-1.
  - Then go to TRIG (clear period_cnt) if enable=1, else IDLE.
  - period_cnt counts continuously from TRIG entry and saturates; it never wraps.
- Latency: distance_ready is registered. The first clk edge sampling the pin low is followed by 2 sync/prev edges, then DONE. Ready is high in the cycle after the 3rd edge.
- distance holds its value between ready pulses; it changes only in DONE.
- Arithmetic: result = floor(high_cycles / CYCLES_PER_CM), where high_cycles counts from the detected rise to the detected fall. Widths come from $clog2 of the parameters. distance is zero-extended to 32 bits.
- enable deassert mid-measurement: the current measurement completes, including ready and HOLDOFF, then goes to IDLE. Re-asserting enable during HOLDOFF continues normally.
- Glitch rejection is not required; it is the synchronizer's responsibility only to be metastability-safe.

Decomposition:
- ranger_pkg holds:
  - state enum: IDLE, TRIG, WAIT_ECHO, MEASURE, DONE, HOLDOFF;
  - default timing constants for 50 MHz;
  - the distance width localparam, 32.
- One sub-module, sync_edge: 2-FF synchronizer plus prev FF, outputs sync, rise, fall, with asynchronous active-low reset. It is reusable for other GPIO inputs.

Test Plan:
All scenarios use sim parameters TRIG_CYCLES=5, CYCLES_PER_CM=10, MAX_CM=20, ECHO_WAIT_CYCLES=50, PERIOD_CYCLES=300.
- Nominal: enable=1, echo high 3 cycles after trigger falls, held for 125 cycles -> trigger high exactly 5 cycles; distance=12, one-cycle distance_ready, timeout=0, next trigger 300 cycles after the first.
- No echo: echo held 0 -> 50 cycles after trigger falls, distance=20, distance_ready=1 and timeout=1 in the same cycle.
- Stuck echo: echo rises and never falls -> after 200 high cycles, distance=20 with timeout=1. An echo still high at the next WAIT_ECHO is ignored until it toggles.
- Boundaries: echo high 9 cycles -> distance=0; high 10 cycles -> distance=1; high 199 cycles -> distance=19 with timeout=0.
- Enable drop: deassert enable during MEASURE -> measurement completes with distance_ready, then IDLE with busy=0 and no further trigger.
- Reset mid-MEASURE: pulse reset_l low -> trigger, distance, distance_ready, busy all 0 immediately (asynchronously); no ready pulse; restart after release with enable=1.
